paddle_source_mux: RTL and testbench

Selects and conditions the player-1 paddle source for the console core. It arbitrates between the USB analog stick (joya_0) and a PS/2 mouse, and integrates mouse deltas into a saturating 8-bit paddle position. It also substitutes mouse buttons into the player-1 button vector. The block sits between hps_io and the core's paddle_1/paddle_2/p_start inputs, running on clk_sys.

---
 rtl/paddle_pkg.sv | 38 +++
 rtl/paddle_source_mux_if.sv | 15 +
 rtl/mouse_axis_acc.sv | 46 ++++
 rtl/paddle_source_mux.sv | 110 +++++++++++
 tb/tb_paddle_source_mux.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types, mouse packet bit positions and saturation helpers
package paddle_pkg;

  typedef enum logic {
    ANALOG = 1'b0,
    MOUSE  = 1'b1
  } state_e;

  localparam int MS_STB     = 24;
  localparam int MS_DY_HI   = 23;
  localparam int MS_DY_LO   = 16;
  localparam int MS_DX_HI   = 15;
  localparam int MS_DX_LO   = 8;
  localparam int MS_DY_SIGN = 5;
  localparam int MS_DX_SIGN = 4;
  localparam int MS_BTN_HI  = 2;

  // Limit a shifted 9-bit delta to +/-lim; lim is at most 127 so 8 bits hold the result.
  function automatic logic signed [7:0] clampd(input logic signed [8:0] v,
                                               input logic signed [8:0] lim);
    logic signed [8:0] neg;
    logic signed [8:0] r;
    neg = -lim;
    if (v > lim)      r = lim;
    else if (v < neg) r = neg;
    else              r = v;
    return r[7:0];
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [9:0] n);
    logic signed [7:0] r;
    if (n > 10'sd127)       r = 8'sh7f;
    else if (n < -10'sd128) r = 8'sh80;
    else                    r = n[7:0];
    return r;
  endfunction

endpackage

// File: rtl/paddle_source_mux_if.sv
// rtl/paddle_source_mux_if.sv - signal bundle for the paddle source mux boundary
interface paddle_source_mux_if;
  logic [24:0] ps2_mouse;
  logic [15:0] joya_0;
  logic [8:0]  joy_0;
  logic [7:0]  paddle_x;
  logic [7:0]  paddle_y;
  logic [8:0]  buttons;
  logic        mouse_active;

  modport master (output ps2_mouse, joya_0, joy_0,
                  input  paddle_x, paddle_y, buttons, mouse_active);
  modport slave  (input  ps2_mouse, joya_0, joy_0,
                  output paddle_x, paddle_y, buttons, mouse_active);
endinterface

// File: rtl/mouse_axis_acc.sv
// rtl/mouse_axis_acc.sv - per-axis mouse delta shift, clamp and saturating accumulate
module mouse_axis_acc
  import paddle_pkg::*;
#(
  parameter int DELTA_SHIFT = 1,
  parameter int DELTA_CLAMP = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       strobe_en_i,
  input  logic       clear_i,
  input  logic       sign_i,
  input  logic [7:0] byte_i,
  output logic [7:0] acc_o,
  output logic [7:0] acc_nxt_o
);

  localparam logic signed [8:0] LIM = 9'(DELTA_CLAMP);

  logic signed [8:0] raw;
  logic signed [8:0] shifted;
  logic signed [7:0] d;
  logic signed [9:0] sum;
  logic [7:0]        acc_q;
  logic [7:0]        acc_d;

  always_comb begin
    raw     = {sign_i, byte_i};
    shifted = raw >>> DELTA_SHIFT;
    d       = clampd(shifted, LIM);
    sum     = {{2{acc_q[7]}}, acc_q} + {{2{d[7]}}, d};
    acc_d   = acc_q;
    // Clear wins so a same-cycle exit to analog never leaves a stale position.
    if (clear_i)          acc_d = 8'h00;
    else if (strobe_en_i) acc_d = sat8(sum);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= 8'h00;
    else       acc_q <= acc_d;
  end

  assign acc_o     = acc_q;
  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/paddle_source_mux.sv
// rtl/paddle_source_mux.sv - player-1 paddle source arbitration between analog stick and PS/2 mouse
module paddle_source_mux
  import paddle_pkg::*;
#(
  parameter int DELTA_SHIFT  = 1,
  parameter int DELTA_CLAMP  = 10,
  parameter int IDLE_TIMEOUT = 0,
  parameter int TIMEOUT_W    = 28
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joya_0,
  input  logic [8:0]  joy_0,
  output logic [7:0]  paddle_x,
  output logic [7:0]  paddle_y,
  output logic [8:0]  buttons,
  output logic        mouse_active
);

  localparam logic [TIMEOUT_W-1:0] IDLE_T = TIMEOUT_W'(IDLE_TIMEOUT);
  localparam bit TIMEOUT_EN = (IDLE_TIMEOUT != 0);

  state_e               state_q, state_d;
  logic                 old_stb_q;
  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic [7:0]           px_q, px_d, py_q, py_d;
  logic [8:0]           btn_q, btn_d;
  logic                 strobe, override, timeout, strobe_en, clear;
  logic [7:0]           accx, accy, accx_nxt, accy_nxt;
  logic                 unused_bits;

  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3], accx, accy};

  always_comb begin
    strobe   = ps2_mouse[MS_STB] ^ old_stb_q;
    override = (joya_0 != 16'h0000);
    timeout  = TIMEOUT_EN && (state_q == MOUSE) && (idle_q == IDLE_T);
    state_d  = state_q;
    case (state_q)
      ANALOG: if (strobe && !override) state_d = MOUSE;
      MOUSE:  if (override || (timeout && !strobe)) state_d = ANALOG;
      default: state_d = ANALOG;
    endcase

    // Accumulators are held at zero whenever the next state is analog.
    clear     = (state_d == ANALOG);
    strobe_en = strobe && (state_d == MOUSE);

    idle_d = idle_q;
    if (clear || strobe)     idle_d = '0;
    else if (idle_q != IDLE_T) idle_d = idle_q + 1'b1;

    if (state_d == MOUSE) begin
      px_d  = accx_nxt;
      py_d  = accy_nxt;
      btn_d = {1'b0, ps2_mouse[MS_BTN_HI:0], joy_0[4:0]};
    end else begin
      px_d  = joya_0[7:0];
      py_d  = joya_0[15:8];
      btn_d = joy_0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ANALOG;
      old_stb_q <= ps2_mouse[MS_STB];
      idle_q    <= '0;
      px_q      <= 8'h00;
      py_q      <= 8'h00;
      btn_q     <= 9'h000;
    end else begin
      state_q   <= state_d;
      old_stb_q <= ps2_mouse[MS_STB];
      idle_q    <= idle_d;
      px_q      <= px_d;
      py_q      <= py_d;
      btn_q     <= btn_d;
    end
  end

  mouse_axis_acc #(.DELTA_SHIFT(DELTA_SHIFT), .DELTA_CLAMP(DELTA_CLAMP)) u_acc_x (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .strobe_en_i(strobe_en),
    .clear_i    (clear),
    .sign_i     (ps2_mouse[MS_DX_SIGN]),
    .byte_i     (ps2_mouse[MS_DX_HI:MS_DX_LO]),
    .acc_o      (accx),
    .acc_nxt_o  (accx_nxt)
  );

  mouse_axis_acc #(.DELTA_SHIFT(DELTA_SHIFT), .DELTA_CLAMP(DELTA_CLAMP)) u_acc_y (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .strobe_en_i(strobe_en),
    .clear_i    (clear),
    .sign_i     (ps2_mouse[MS_DY_SIGN]),
    .byte_i     (ps2_mouse[MS_DY_HI:MS_DY_LO]),
    .acc_o      (accy),
    .acc_nxt_o  (accy_nxt)
  );

  assign paddle_x     = px_q;
  assign paddle_y     = py_q;
  assign buttons      = btn_q;
  assign mouse_active = (state_q == MOUSE);

endmodule

// File: tb/tb_paddle_source_mux.sv
// tb/tb_paddle_source_mux.sv - self-checking bench for paddle_source_mux against a behavioural model
module tb_paddle_source_mux;

  localparam int SH = 1;
  localparam int CL = 10;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  paddle_source_mux_if pif ();

  paddle_source_mux #(
    .DELTA_SHIFT(SH), .DELTA_CLAMP(CL), .IDLE_TIMEOUT(TO), .TIMEOUT_W(28)
  ) dut (
    .clk_sys     (clk),
    .reset       (rst),
    .ps2_mouse   (pif.ps2_mouse),
    .joya_0      (pif.joya_0),
    .joy_0       (pif.joy_0),
    .paddle_x    (pif.paddle_x),
    .paddle_y    (pif.paddle_y),
    .buttons     (pif.buttons),
    .mouse_active(pif.mouse_active)
  );

  int total = 0;
  int bad   = 0;

  bit m_mouse;
  int m_x, m_y, m_idle;
  bit m_old;
  bit cur_stb;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int delta(input bit s, input logic [7:0] b);
    int raw;
    raw = s ? int'(b) - 256 : int'(b);
    return clip(raw >>> SH, -CL, CL);
  endfunction

  function automatic logic [24:0] pkt(input bit stb, input bit dys, input logic [7:0] dy,
                                      input bit dxs, input logic [7:0] dx, input logic [2:0] btn);
    return {stb, dy, dx, 2'b00, dys, dxs, 1'b0, btn};
  endfunction

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic apply(input logic r, input logic [24:0] pm, input logic [15:0] ja,
                       input logic [8:0] j);
    bit ev;
    logic [7:0] ex, ey;
    logic [8:0] eb;
    logic ea;
    rst = r;
    pif.ps2_mouse = pm;
    pif.joya_0 = ja;
    pif.joy_0 = j;
    if (r) begin
      m_mouse = 0; m_x = 0; m_y = 0; m_idle = 0; m_old = pm[24];
    end else begin
      ev = (pm[24] != m_old);
      m_old = pm[24];
      if (ja != 16'h0) begin
        m_mouse = 0; m_x = 0; m_y = 0; m_idle = 0;
      end else if (ev) begin
        m_mouse = 1;
        m_x = clip(m_x + delta(pm[4], pm[15:8]), -128, 127);
        m_y = clip(m_y + delta(pm[5], pm[23:16]), -128, 127);
        m_idle = 0;
      end else if (m_mouse) begin
        if (m_idle == TO) begin
          m_mouse = 0; m_x = 0; m_y = 0; m_idle = 0;
        end else m_idle++;
      end
    end
    if (r) begin
      ex = 8'h00; ey = 8'h00; eb = 9'h000; ea = 1'b0;
    end else if (m_mouse) begin
      ex = 8'(m_x); ey = 8'(m_y); eb = {1'b0, pm[2:0], j[4:0]}; ea = 1'b1;
    end else begin
      ex = ja[7:0]; ey = ja[15:8]; eb = j; ea = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("paddle_x", {1'b0, pif.paddle_x}, {1'b0, ex});
    chk("paddle_y", {1'b0, pif.paddle_y}, {1'b0, ey});
    chk("buttons", pif.buttons, eb);
    chk("mouse_active", {8'h00, pif.mouse_active}, {8'h00, ea});
  endtask

  task automatic pkt_x(input bit s, input logic [7:0] b, input logic [15:0] ja);
    cur_stb = ~cur_stb;
    apply(1'b0, pkt(cur_stb, 1'b0, 8'h00, s, b, 3'b000), ja, 9'h000);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b0, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000), 16'h0, 9'h000);
  endtask

  initial begin
    logic [24:0] pm;
    logic [15:0] ja;

    // Reset with strobe high, then one toggle right after release.
    cur_stb = 1'b1;
    apply(1'b1, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000), 16'h0, 9'h000);
    apply(1'b1, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000), 16'h0, 9'h000);
    chk("reset_x", {1'b0, pif.paddle_x}, 9'h000);
    chk("reset_active", {8'h00, pif.mouse_active}, 9'h000);
    pkt_x(1'b0, 8'd0, 16'h0);
    chk("first_event_active", {8'h00, pif.mouse_active}, 9'h001);
    idle(3);

    // Analog selection.
    apply(1'b0, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000), 16'h40C0, 9'h011);
    chk("analog_x", {1'b0, pif.paddle_x}, 9'h0C0);
    chk("analog_y", {1'b0, pif.paddle_y}, 9'h040);
    chk("analog_btn", pif.buttons, 9'h011);

    // Positive integration to saturation, then negative to saturation.
    pkt_x(1'b0, 8'd40, 16'h0);
    chk("first_pkt_x", {1'b0, pif.paddle_x}, 9'h00A);
    for (int k = 0; k < 13; k++) pkt_x(1'b0, 8'd40, 16'h0);
    chk("sat_pos", {1'b0, pif.paddle_x}, 9'h07F);
    pkt_x(1'b0, 8'd40, 16'h0);
    chk("sat_pos_hold", {1'b0, pif.paddle_x}, 9'h07F);
    for (int k = 0; k < 26; k++) pkt_x(1'b1, 8'h01, 16'h0);
    chk("sat_neg", {1'b0, pif.paddle_x}, 9'h080);

    // Mouse button substitution.
    apply(1'b0, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b101), 16'h0, 9'h1FF);
    chk("mouse_btn", pif.buttons, 9'h0BF);

    // Analog override in the same cycle as a strobe, then re-entry from zero.
    pkt_x(1'b0, 8'd20, 16'h0001);
    chk("override_x", {1'b0, pif.paddle_x}, 9'h001);
    chk("override_active", {8'h00, pif.mouse_active}, 9'h000);
    pkt_x(1'b0, 8'd20, 16'h0);
    chk("reentry_x", {1'b0, pif.paddle_x}, 9'h00A);

    // Idle timeout: active for 100 cycles after the packet, analog on the 101st.
    pkt_x(1'b0, 8'd4, 16'h0);
    idle(TO);
    chk("timeout_still", {8'h00, pif.mouse_active}, 9'h001);
    idle(1);
    chk("timeout_drop", {8'h00, pif.mouse_active}, 9'h000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ja = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 1) == 1) cur_stb = ~cur_stb;
      pm = pkt(cur_stb, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 3'($urandom));
      apply(1'b0, pm, ja, 9'($urandom));
    end

    // Reset in mouse mode at paddle_x = 50.
    apply(1'b0, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b000), 16'h0001, 9'h000);
    for (int k = 0; k < 5; k++) pkt_x(1'b0, 8'd20, 16'h0);
    chk("pre_reset_x", {1'b0, pif.paddle_x}, 9'd50);
    apply(1'b1, pkt(cur_stb, 1'b0, 8'h00, 1'b0, 8'h00, 3'b111), 16'h0, 9'h1FF);
    chk("mid_reset_x", {1'b0, pif.paddle_x}, 9'h000);
    chk("mid_reset_btn", pif.buttons, 9'h000);
    chk("mid_reset_active", {8'h00, pif.mouse_active}, 9'h000);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
